mode_counter: RTL and testbench
===============================

# mode_counter

Parametrised multi-mode counter register for the ReWire regression/datapath set. It generalises the 8-bit increment/rotate-left counter to any width. It adds decrement, rotate-right, load, hold and clear modes, a configurable step, a per-cycle enable, and wrap/terminal-count status. The block is the state element under a small controller: one command per enabled cycle, with the result registered.

## Interface
- `WIDTH`, default 8: counter width in bits, at least 2.
- `STEP`, default 1: increment/decrement amount, 1 ≤ STEP < 2^WIDTH.
- `INIT`, default 0: reset and clear value, WIDTH bits.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: command valid; no state change when 0.
- `mode`, input, 3: command select (see Operation).
- `load_val`, input, WIDTH: value for LOAD mode.
- `count`, output, WIDTH: registered counter value.
- `wrap`, output, 1: one-cycle pulse, registered; set when the last INC/DEC crossed the range boundary.
- `ovf`, output, 1: sticky, set by any wrap (or saturation), cleared by LOAD/CLEAR or reset.
- `at_max`, output, 1: combinational, `count == 2^WIDTH-1`.
- `at_zero`, output, 1: combinational, `count == 0`.

## Operation
- Modes when `en`=1:
  - 0 INC: count + STEP.
  - 1 ROTL: {count[W-2:0], count[W-1]}.
  - 2 DEC: count − STEP.
  - 3 ROTR: {count[0], count[W-1:1]}.
  - 4 LOAD: load_val.
  - 5 HOLD: no change.
  - 6 SHL: count << 1, zero fill.
  - 7 CLEAR: INIT.
- INC/DEC arithmetic uses a WIDTH+1-bit sum. The carry-out (INC) or borrow (DEC) defines a boundary crossing.
- Without `SATURATE_EN`, the result wraps modulo 2^WIDTH.
- Rotate and shift never assert `wrap`. SHL discards the MSB silently.
- `wrap` is registered from the crossing of the current command. It is 0 on every cycle with no crossing, including `en`=0 cycles.
- `ovf` is set on crossing. LOAD/CLEAR clear it. If a crossing and a LOAD/CLEAR coincide, this is impossible, since there is one mode per cycle.
- `en`=0: count, ovf held; wrap forced 0.
- HOLD with `en`=1 behaves as `en`=0 except that it is counted as a command (no difference in outputs).

## Timing
- Reset (rst=0, asynchronous assert): count=INIT, wrap=0, ovf=0 immediately. Release is synchronous to the next clk edge; the first command is accepted on the first rising edge with rst=1.
- Latency: command sampled at edge N is reflected on `count`, `wrap` and `ovf` after edge N, one cycle.
- `at_max`/`at_zero` follow `count` combinationally: zero extra latency.
- Reset asserted mid-sequence discards any in-progress command; no partial update.
- Back-to-back commands are fully supported; there is no busy state.

## Configuration
- `MODE_COUNTER_SATURATE_EN` defined:
  - INC clamps at 2^WIDTH−1; DEC clamps at 0.
  - An attempted crossing still pulses `wrap` and sets `ovf`, but count stays at the bound.
  - Rotate, shift and load are unaffected.
- Not defined: INC/DEC wrap modulo 2^WIDTH as in Operation.

## Test plan
- Reset: WIDTH=8, INIT=0x00. Assert rst=0 mid-count at 0x37 -> count=0x00, wrap=0, ovf=0 without a clock edge.
- INC wrap: WIDTH=8, STEP=1, load 0xFE, then INC twice -> 0xFF (at_max=1), then 0x00 with wrap=1 for one cycle and ovf=1 sticky. With SATURATE_EN: 0xFF, 0xFF, wrap=1, ovf=1.
- Rotates: load 0x81, ROTL -> 0x03. Load 0x81, ROTR -> 0xC0. Load 0x81, SHL -> 0x02. wrap=0 throughout.
- DEC with STEP=3: load 0x02, DEC -> 0xFF, wrap=1 (saturate build: 0x00, at_zero=1).
- Enable/hold: INC with en=0 for 5 cycles -> count unchanged, wrap=0. Then HOLD with en=1 -> unchanged. Then LOAD 0x5A -> 0x5A and ovf cleared.
- Width sweep: WIDTH=16, STEP=0x100, load 0xFF80, INC -> 0x0080, wrap=1. CLEAR -> INIT, ovf=0.

Source files
------------

// File: rtl/mode_counter_if.sv
// Command/status bundle between a controller (master) and the mode_counter (slave).
// WIDTH must match the WIDTH of the mode_counter it is bound to.
interface mode_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             ovf;
    logic             at_max;
    logic             at_zero;

    modport master (
        output en, mode, load_val,
        input  count, wrap, ovf, at_max, at_zero
    );

    modport slave (
        input  en, mode, load_val,
        output count, wrap, ovf, at_max, at_zero
    );
endinterface

// File: rtl/mode_counter.sv
// Parametrised multi-mode counter register: one command per enabled cycle, registered result.
// Optional feature macro MODE_COUNTER_SATURATE_EN: INC/DEC clamp at the range bounds instead of wrapping.
module mode_counter #(
    parameter int               WIDTH = 8,
    parameter int               STEP  = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input logic            clk,
    input logic            rst,
    mode_counter_if.slave  bus
);

    typedef enum logic [2:0] {
        MODE_INC   = 3'd0,
        MODE_ROTL  = 3'd1,
        MODE_DEC   = 3'd2,
        MODE_ROTR  = 3'd3,
        MODE_LOAD  = 3'd4,
        MODE_HOLD  = 3'd5,
        MODE_SHL   = 3'd6,
        MODE_CLEAR = 3'd7
    } modeT;

    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    logic [WIDTH-1:0] countQ;
    logic             wrapQ;
    logic             ovfQ;

    logic [WIDTH:0]   incSum;
    logic [WIDTH:0]   decDiff;
    logic             incCarry;
    logic             decBorrow;

    logic [WIDTH-1:0] nextCount;
    logic             crossing;
    logic             clearOvf;
    modeT             cmd;

    assign cmd = modeT'(bus.mode);

    // The extra top bit of the widened sum is the carry (INC) or borrow (DEC).
    assign incSum    = {1'b0, countQ} + STEP_EXT;
    assign decDiff   = {1'b0, countQ} - STEP_EXT;
    assign incCarry  = incSum[WIDTH];
    assign decBorrow = decDiff[WIDTH];

    always_comb begin
        nextCount = countQ;
        crossing  = 1'b0;
        clearOvf  = 1'b0;
        if (bus.en) begin
            case (cmd)
                MODE_INC: begin
                    crossing = incCarry;
`ifdef MODE_COUNTER_SATURATE_EN
                    nextCount = incCarry ? MAX_VAL : incSum[WIDTH-1:0];
`else
                    nextCount = incSum[WIDTH-1:0];
`endif
                end
                MODE_DEC: begin
                    crossing = decBorrow;
`ifdef MODE_COUNTER_SATURATE_EN
                    nextCount = decBorrow ? '0 : decDiff[WIDTH-1:0];
`else
                    nextCount = decDiff[WIDTH-1:0];
`endif
                end
                MODE_ROTL:  nextCount = {countQ[WIDTH-2:0], countQ[WIDTH-1]};
                MODE_ROTR:  nextCount = {countQ[0], countQ[WIDTH-1:1]};
                MODE_SHL:   nextCount = {countQ[WIDTH-2:0], 1'b0};
                MODE_LOAD: begin
                    nextCount = bus.load_val;
                    clearOvf  = 1'b1;
                end
                MODE_CLEAR: begin
                    nextCount = INIT;
                    clearOvf  = 1'b1;
                end
                MODE_HOLD:  nextCount = countQ;
                default:    nextCount = countQ;
            endcase
        end
    end

    // wrap is recomputed every cycle so it can never linger past the crossing command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countQ <= INIT;
            wrapQ  <= 1'b0;
            ovfQ   <= 1'b0;
        end else begin
            countQ <= nextCount;
            wrapQ  <= crossing;
            if (clearOvf) begin
                ovfQ <= 1'b0;
            end else if (crossing) begin
                ovfQ <= 1'b1;
            end
        end
    end

    assign bus.count   = countQ;
    assign bus.wrap    = wrapQ;
    assign bus.ovf     = ovfQ;
    assign bus.at_max  = (countQ == MAX_VAL);
    assign bus.at_zero = (countQ == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Directed testbench for mode_counter: three instances (8-bit STEP=1, 8-bit STEP=3, 16-bit STEP=0x100).
// Expectations follow the MODE_COUNTER_SATURATE_EN setting of the build.
module tb_mode_counter;

`ifdef MODE_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [2:0] INC = 3'd0, ROTL = 3'd1, DEC = 3'd2, ROTR = 3'd3;
    localparam logic [2:0] LOAD = 3'd4, HOLD = 3'd5, SHL = 3'd6, CLEAR = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mode_counter_if #(.WIDTH(8))  busA ();
    mode_counter_if #(.WIDTH(8))  busB ();
    mode_counter_if #(.WIDTH(16)) busC ();

    mode_counter #(.WIDTH(8),  .STEP(1),      .INIT(8'h00))    dutA (.clk(clk), .rst(rst), .bus(busA));
    mode_counter #(.WIDTH(8),  .STEP(3),      .INIT(8'h00))    dutB (.clk(clk), .rst(rst), .bus(busB));
    mode_counter #(.WIDTH(16), .STEP(16'h100), .INIT(16'h1234)) dutC (.clk(clk), .rst(rst), .bus(busC));

    // Each issue task drives one command across a single rising edge, then samples 1 time unit later.
    task automatic issueA(input logic [2:0] m, input logic [7:0] v);
        @(negedge clk); busA.en = 1'b1; busA.mode = m; busA.load_val = v;
        @(posedge clk); #1; busA.en = 1'b0;
    endtask

    task automatic issueB(input logic [2:0] m, input logic [7:0] v);
        @(negedge clk); busB.en = 1'b1; busB.mode = m; busB.load_val = v;
        @(posedge clk); #1; busB.en = 1'b0;
    endtask

    task automatic issueC(input logic [2:0] m, input logic [15:0] v);
        @(negedge clk); busC.en = 1'b1; busC.mode = m; busC.load_val = v;
        @(posedge clk); #1; busC.en = 1'b0;
    endtask

    task automatic releaseReset();
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        releaseReset();
        @(posedge clk); #1;
        vectors++; if (busA.count !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_countA: got %h expected 00", busA.count); end
        vectors++; if (busA.at_zero !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_atzeroA: got %b expected 1", busA.at_zero); end
        vectors++; if (busC.count !== 16'h1234) begin miscompares++; $display("[TB] FAIL reset_countC: got %h expected 1234", busC.count); end
        issueA(LOAD, 8'h36);
        issueA(INC, 8'h00);
        vectors++; if (busA.count !== 8'h37) begin miscompares++; $display("[TB] FAIL pre_reset_count: got %h expected 37", busA.count); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (busA.count !== 8'h00) begin miscompares++; $display("[TB] FAIL async_reset_count: got %h expected 00", busA.count); end
        vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_wrap: got %b expected 0", busA.wrap); end
        vectors++; if (busA.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_ovf: got %b expected 0", busA.ovf); end
        releaseReset();
    endtask

    task automatic test_inc_wrap();
        issueA(LOAD, 8'hFE);
        issueA(INC, 8'h00);
        vectors++; if (busA.count !== 8'hFF) begin miscompares++; $display("[TB] FAIL inc1_count: got %h expected ff", busA.count); end
        vectors++; if (busA.at_max !== 1'b1) begin miscompares++; $display("[TB] FAIL inc1_atmax: got %b expected 1", busA.at_max); end
        vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL inc1_wrap: got %b expected 0", busA.wrap); end
        issueA(INC, 8'h00);
        vectors++; if (busA.count !== (SAT ? 8'hFF : 8'h00)) begin miscompares++; $display("[TB] FAIL inc2_count: got %h expected %h", busA.count, SAT ? 8'hFF : 8'h00); end
        vectors++; if (busA.wrap !== 1'b1) begin miscompares++; $display("[TB] FAIL inc2_wrap: got %b expected 1", busA.wrap); end
        vectors++; if (busA.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL inc2_ovf: got %b expected 1", busA.ovf); end
        @(posedge clk); #1;
        vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_pulse_len: got %b expected 0", busA.wrap); end
        vectors++; if (busA.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b expected 1", busA.ovf); end
    endtask

    task automatic test_rotate();
        issueA(LOAD, 8'h81);
        issueA(ROTL, 8'h00);
        vectors++; if (busA.count !== 8'h03) begin miscompares++; $display("[TB] FAIL rotl: got %h expected 03", busA.count); end
        vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL rotl_wrap: got %b expected 0", busA.wrap); end
        issueA(LOAD, 8'h81);
        issueA(ROTR, 8'h00);
        vectors++; if (busA.count !== 8'hC0) begin miscompares++; $display("[TB] FAIL rotr: got %h expected c0", busA.count); end
        issueA(LOAD, 8'h81);
        issueA(SHL, 8'h00);
        vectors++; if (busA.count !== 8'h02) begin miscompares++; $display("[TB] FAIL shl: got %h expected 02", busA.count); end
        vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_wrap: got %b expected 0", busA.wrap); end
        issueA(ROTR, 8'h00);
        vectors++; if (busA.count !== 8'h01) begin miscompares++; $display("[TB] FAIL rotr2: got %h expected 01", busA.count); end
        issueA(ROTR, 8'h00);
        vectors++; if (busA.count !== 8'h80) begin miscompares++; $display("[TB] FAIL rotr_lsb_to_msb: got %h expected 80", busA.count); end
    endtask

    task automatic test_dec_step3();
        issueB(LOAD, 8'h10);
        issueB(DEC, 8'h00);
        vectors++; if (busB.count !== 8'h0D) begin miscompares++; $display("[TB] FAIL dec_plain: got %h expected 0d", busB.count); end
        vectors++; if (busB.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL dec_plain_wrap: got %b expected 0", busB.wrap); end
        issueB(LOAD, 8'h02);
        issueB(DEC, 8'h00);
        vectors++; if (busB.count !== (SAT ? 8'h00 : 8'hFF)) begin miscompares++; $display("[TB] FAIL dec_cross: got %h expected %h", busB.count, SAT ? 8'h00 : 8'hFF); end
        vectors++; if (busB.at_zero !== SAT) begin miscompares++; $display("[TB] FAIL dec_cross_atzero: got %b expected %b", busB.at_zero, SAT); end
        vectors++; if (busB.wrap !== 1'b1) begin miscompares++; $display("[TB] FAIL dec_cross_wrap: got %b expected 1", busB.wrap); end
        vectors++; if (busB.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL dec_cross_ovf: got %b expected 1", busB.ovf); end
        issueB(LOAD, 8'hFE);
        issueB(INC, 8'h00);
        vectors++; if (busB.count !== (SAT ? 8'hFF : 8'h01)) begin miscompares++; $display("[TB] FAIL inc3_cross: got %h expected %h", busB.count, SAT ? 8'hFF : 8'h01); end
        vectors++; if (busB.wrap !== 1'b1) begin miscompares++; $display("[TB] FAIL inc3_cross_wrap: got %b expected 1", busB.wrap); end
        // Reset while wrap and ovf are both high must drop them without a clock edge.
        #2 rst = 1'b0;
        #1;
        vectors++; if (busB.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_wrap: got %b expected 0", busB.wrap); end
        vectors++; if (busB.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ovf: got %b expected 0", busB.ovf); end
        vectors++; if (busB.count !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_count: got %h expected 00", busB.count); end
        releaseReset();
    endtask

    task automatic test_enable_hold();
        issueA(LOAD, 8'hFF);
        issueA(INC, 8'h00);
        @(negedge clk); busA.en = 1'b0; busA.mode = INC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (busA.count !== (SAT ? 8'hFF : 8'h00)) begin miscompares++; $display("[TB] FAIL en0_count[%0d]: got %h expected %h", i, busA.count, SAT ? 8'hFF : 8'h00); end
            vectors++; if (busA.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL en0_wrap[%0d]: got %b expected 0", i, busA.wrap); end
        end
        vectors++; if (busA.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL en0_ovf: got %b expected 1", busA.ovf); end
        issueA(HOLD, 8'h77);
        vectors++; if (busA.count !== (SAT ? 8'hFF : 8'h00)) begin miscompares++; $display("[TB] FAIL hold_count: got %h expected %h", busA.count, SAT ? 8'hFF : 8'h00); end
        vectors++; if (busA.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_ovf: got %b expected 1", busA.ovf); end
        issueA(LOAD, 8'h5A);
        vectors++; if (busA.count !== 8'h5A) begin miscompares++; $display("[TB] FAIL load_count: got %h expected 5a", busA.count); end
        vectors++; if (busA.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL load_ovf: got %b expected 0", busA.ovf); end
    endtask

    task automatic test_width16();
        issueC(LOAD, 16'hFF80);
        issueC(INC, 16'h0000);
        vectors++; if (busC.count !== (SAT ? 16'hFFFF : 16'h0080)) begin miscompares++; $display("[TB] FAIL w16_inc: got %h expected %h", busC.count, SAT ? 16'hFFFF : 16'h0080); end
        vectors++; if (busC.wrap !== 1'b1) begin miscompares++; $display("[TB] FAIL w16_wrap: got %b expected 1", busC.wrap); end
        vectors++; if (busC.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL w16_ovf: got %b expected 1", busC.ovf); end
        issueC(CLEAR, 16'h0000);
        vectors++; if (busC.count !== 16'h1234) begin miscompares++; $display("[TB] FAIL w16_clear: got %h expected 1234", busC.count); end
        vectors++; if (busC.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL w16_clear_ovf: got %b expected 0", busC.ovf); end
    endtask

    task automatic test_back_to_back();
        issueC(INC, 16'h0000);
        vectors++; if (busC.count !== 16'h1334) begin miscompares++; $display("[TB] FAIL b2b_inc1: got %h expected 1334", busC.count); end
        issueC(INC, 16'h0000);
        vectors++; if (busC.count !== 16'h1434) begin miscompares++; $display("[TB] FAIL b2b_inc2: got %h expected 1434", busC.count); end
        issueC(DEC, 16'h0000);
        vectors++; if (busC.count !== 16'h1334) begin miscompares++; $display("[TB] FAIL b2b_dec: got %h expected 1334", busC.count); end
        issueC(ROTL, 16'h0000);
        vectors++; if (busC.count !== 16'h2668) begin miscompares++; $display("[TB] FAIL b2b_rotl: got %h expected 2668", busC.count); end
        vectors++; if (busC.wrap !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_wrap: got %b expected 0", busC.wrap); end
    endtask

    initial begin
        busA.en = 1'b0; busA.mode = HOLD; busA.load_val = '0;
        busB.en = 1'b0; busB.mode = HOLD; busB.load_val = '0;
        busC.en = 1'b0; busC.mode = HOLD; busC.load_val = '0;
        #12;
        test_reset();
        test_inc_wrap();
        test_rotate();
        test_dec_step3();
        test_enable_hold();
        test_width16();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
